fp_addsub: RTL and testbench
============================

FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (at least 4).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (at least 4); operand width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand set valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have ports a and b, input, W, IEEE-754-format operands.
REQ-008 SHALL have port op, input, 1, operation: 0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port z, output, W, result.
REQ-012 SHALL have port flags, output, 4, {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-013 SHALL use FSM states IDLE, SPECIAL, ALIGN, ADD, NORM, ROUND, OUT.
REQ-014 SHALL accept on in_valid && in_ready: register a, b, op; go IDLE->SPECIAL. in_ready = 1 only in IDLE; no overlap of operations.
REQ-015 SHALL, in SPECIAL, unpack fields (hidden bit 1 if exp != 0, else 0 with exponent 1), flip b sign when op = 1, and resolve special cases; special-case results go directly to OUT.
REQ-016 SHALL return canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0) for any NaN input or for inf-inf under effective subtraction; set invalid for sNaN input or inf-inf.
REQ-017 SHALL return the infinity for inf combined with a finite value, or same-signed infinities; no flags set.
REQ-018 SHALL, in ALIGN, right-shift the smaller-exponent mantissa by the exponent difference in one cycle; shifted-out bits OR into sticky; shift saturates at MAN_W+3.
REQ-019 SHALL, in ADD, add or subtract magnitudes (larger minus smaller) in a MAN_W+5-bit datapath; result sign = sign of larger magnitude.
REQ-020 SHALL, in NORM, normalise in one cycle using a leading-zero count: right-shift 1 on carry-out, else left-shift by min(lzc, exp-1), so subnormal results retain exponent 1 with hidden bit 0.
REQ-021 SHALL, in ROUND, round to nearest, ties to even (guard, round, sticky), handle mantissa carry with exponent increment, then pack.
REQ-022 SHALL set inexact when any of guard/round/sticky is 1 after normalisation.
REQ-023 SHALL, when the rounded exponent is all-ones or more, return same-signed infinity and set overflow and inexact.
REQ-024 SHALL set underflow when the result is subnormal or zero before rounding and inexact.
REQ-025 SHALL produce an exact zero result of +0, except (-0)+(-0) = -0.
REQ-026 SHALL hold out_valid, z and flags stable in OUT until out_ready; on transfer go to IDLE, so in_ready = 1 the next cycle.
REQ-027 SHALL have latency: operands accepted at edge k give out_valid after edge k+6 on the normal path and after edge k+2 for special cases.

Reset
REQ-028 SHALL, on rst, at the next edge, abort any operation and reset: state = IDLE, in_ready = 1, out_valid = 0, z = 0, flags = 0.
REQ-029 SHALL give rst priority over a simultaneous handshake; an operation aborted mid-flight produces no output.

Structure
REQ-030 SHALL place the FSM state enum, the flag bit index constants and the qNaN/infinity pattern functions in package fp_pkg.
REQ-031 SHALL use one sub-module, fp_lzc, a parametrised leading-zero counter of width MAN_W+5, used by NORM.

Verification
REQ-032 SHALL cover, at default parameters, 0x3F800000 + 0x40000000 (op = 0) -> z = 0x40400000, flags = 0, out_valid exactly 6 cycles after accept.
REQ-033 SHALL cover 0x3F800000 - 0x3F800000 (op = 1) -> z = 0x00000000, flags = 0.
REQ-034 SHALL cover 0x7F800000 + 0xFF800000 -> z = 0x7FC00000, invalid = 1, out_valid 2 cycles after accept.
REQ-035 SHALL cover 0x7F7FFFFF + 0x7F7FFFFF -> z = 0x7F800000, overflow = 1, inexact = 1.
REQ-036 SHALL cover 0x3F800000 + 0x33800000 -> z = 0x3F800000 (tie to even), inexact = 1; and 0x00000001 + 0x00000001 -> z = 0x00000002, flags = 0.
REQ-037 SHALL cover, with EXP_W = 5 and MAN_W = 10, 0x3C00 + 0x3C00 -> 0x4000, with out_ready held low 5 cycles (z stable, in_ready = 0), then rst asserted mid-operation -> no out_valid and in_ready = 1 after the next edge.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the multi-cycle IEEE-754 adder/subtractor.
// Special-value patterns are built for any exponent/fraction split up to 64 bits.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        OUT
    } state_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic logic [63:0] qnan_pattern(input int exp_w, input int man_w);
        logic [63:0] p;
        p = ((64'd1 << exp_w) - 64'd1) << man_w;
        p = p | (64'd1 << (man_w - 1));
        return p;
    endfunction

    function automatic logic [63:0] inf_pattern(input logic sign, input int exp_w, input int man_w);
        logic [63:0] p;
        p = ((64'd1 << exp_w) - 64'd1) << man_w;
        p = p | (64'(sign) << (exp_w + man_w));
        return p;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 28,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din_i,
    output logic [CW-1:0]    count_o
);

    // Later (higher) set bits overwrite earlier ones, leaving the MSB-most hit.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din_i[i]) count_o = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 add/subtract, round-to-nearest-even, valid/ready on both sides.
// Datapath word: {carry, hidden, fraction, guard, round, sticky}.
module fp_addsub
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
    output logic [3:0]             flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int N   = MAN_W + 5;
    localparam int XW  = EXP_W + 1;
    localparam int CW  = $clog2(N + 1);
    localparam int SHW = $clog2(N);
    localparam logic [XW-1:0]  EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [SHW-1:0] SH_SAT  = SHW'(MAN_W + 3);
    localparam logic [W-1:0]   QNAN    = W'(qnan_pattern(EXP_W, MAN_W));
    localparam logic [W-1:0]   PINF    = W'(inf_pattern(1'b0, EXP_W, MAN_W));
    localparam logic [W-1:0]   NINF    = W'(inf_pattern(1'b1, EXP_W, MAN_W));

    state_e state_q, state_d;

    logic [W-1:0]  a_q, b_q;
    logic          op_q;
    logic [N-1:0]  big_q, small_q, sum_q, norm_q;
    logic [XW-1:0] exp_q;
    logic          sbig_q, ssmall_q, sign_q;
    logic [W-1:0]  z_q;
    logic [3:0]    flags_q;
    logic          out_valid_q;

    // Field unpack; operands stay held in a_q/b_q for the whole operation.
    logic [EXP_W-1:0] fa_exp, fb_exp;
    logic [MAN_W-1:0] fa_man, fb_man;
    logic             sa, sb, zneg;
    logic [XW-1:0]    ea, eb;
    logic [MAN_W:0]   ma, mb;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;

    assign fa_exp = a_q[W-2:MAN_W];
    assign fb_exp = b_q[W-2:MAN_W];
    assign fa_man = a_q[MAN_W-1:0];
    assign fb_man = b_q[MAN_W-1:0];
    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1] ^ op_q;
    assign zneg   = sa & sb;
    assign ea     = (fa_exp == '0) ? XW'(1) : {1'b0, fa_exp};
    assign eb     = (fb_exp == '0) ? XW'(1) : {1'b0, fb_exp};
    assign ma     = {|fa_exp, fa_man};
    assign mb     = {|fb_exp, fb_man};
    assign a_nan  = (&fa_exp) && (|fa_man);
    assign b_nan  = (&fb_exp) && (|fb_man);
    assign a_snan = a_nan && !fa_man[MAN_W-1];
    assign b_snan = b_nan && !fb_man[MAN_W-1];
    assign a_inf  = (&fa_exp) && !(|fa_man);
    assign b_inf  = (&fb_exp) && !(|fb_man);

    logic          spec_hit_d;
    logic [W-1:0]  spec_z_d;
    logic [3:0]    spec_flags_d;

    always_comb begin
        spec_hit_d   = 1'b1;
        spec_z_d     = QNAN;
        spec_flags_d = '0;
        if (a_nan || b_nan) begin
            spec_flags_d[FLAG_INVALID] = a_snan | b_snan;
        end else if (a_inf && b_inf) begin
            if (sa != sb) spec_flags_d[FLAG_INVALID] = 1'b1;
            else          spec_z_d = sa ? NINF : PINF;
        end else if (a_inf) begin
            spec_z_d = sa ? NINF : PINF;
        end else if (b_inf) begin
            spec_z_d = sb ? NINF : PINF;
        end else begin
            spec_hit_d = 1'b0;
        end
    end

    // ALIGN: one-cycle sticky right shift of the smaller-exponent operand.
    logic          a_big;
    logic [XW-1:0] diff;
    logic [SHW-1:0] sh;
    logic [N-1:0]  ext_small, lost_mask, aligned_d;

    always_comb begin
        a_big     = (ea >= eb);
        diff      = a_big ? (ea - eb) : (eb - ea);
        sh        = (32'(diff) > MAN_W + 3) ? SH_SAT : SHW'(diff);
        ext_small = {1'b0, (a_big ? mb : ma), 3'b000};
        lost_mask = ~({N{1'b1}} << sh);
        aligned_d = (ext_small >> sh) | {{(N-1){1'b0}}, |(ext_small & lost_mask)};
    end

    logic [N-1:0] sum_d;
    logic         sign_d;

    always_comb begin
        sum_d  = big_q + small_q;
        sign_d = sbig_q;
        if (sbig_q != ssmall_q) begin
            if (big_q >= small_q) begin
                sum_d = big_q - small_q;
            end else begin
                sum_d  = small_q - big_q;
                sign_d = ssmall_q;
            end
        end
    end

    // NORM: left shift is capped so the exponent never drops below 1.
    logic [CW-1:0] lzc_cnt;
    logic [31:0]   lz_h, lim, lsh;
    logic [N-1:0]  norm_d;
    logic [XW-1:0] exp_norm_d;

    fp_lzc #(.WIDTH(N)) u_lzc (
        .din_i   (sum_q),
        .count_o (lzc_cnt)
    );

    always_comb begin
        lz_h = 32'(lzc_cnt) - 32'd1;
        lim  = 32'(exp_q) - 32'd1;
        lsh  = (lz_h < lim) ? lz_h : lim;
        if (sum_q[N-1]) begin
            norm_d     = {1'b0, sum_q[N-1:2], sum_q[1] | sum_q[0]};
            exp_norm_d = exp_q + XW'(1);
        end else begin
            norm_d     = sum_q << lsh;
            exp_norm_d = exp_q - XW'(lsh);
        end
    end

    logic               inexact, rup, tiny;
    logic [MAN_W+1:0]   mant_d;
    logic [XW-1:0]      exp_r;
    logic [W-1:0]       round_z_d;
    logic [3:0]         round_flags_d;

    always_comb begin
        inexact = |norm_q[2:0];
        rup     = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        tiny    = !norm_q[N-2];
        mant_d  = norm_q[N-1:3] + (MAN_W+2)'(rup);
        exp_r   = exp_q;
        if (mant_d[MAN_W+1]) begin
            mant_d = mant_d >> 1;
            exp_r  = exp_q + XW'(1);
        end
        round_flags_d = '0;
        round_flags_d[FLAG_INEXACT]   = inexact;
        round_flags_d[FLAG_UNDERFLOW] = tiny & inexact;
        if (exp_r >= EXP_MAX) begin
            round_z_d = sign_q ? NINF : PINF;
            round_flags_d[FLAG_OVERFLOW] = 1'b1;
            round_flags_d[FLAG_INEXACT]  = 1'b1;
        end else if (mant_d == '0 && !inexact) begin
            round_z_d = {zneg, {(W-1){1'b0}}};
        end else begin
            round_z_d = {sign_q, (mant_d[MAN_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}),
                         mant_d[MAN_W-1:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SPECIAL;
            SPECIAL: state_d = spec_hit_d ? OUT : ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // out_valid rises one cycle after entering OUT, z is already loaded by then.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                end
                SPECIAL: if (spec_hit_d) begin
                    z_q     <= spec_z_d;
                    flags_q <= spec_flags_d;
                end
                ALIGN: begin
                    big_q    <= {1'b0, (a_big ? ma : mb), 3'b000};
                    small_q  <= aligned_d;
                    exp_q    <= a_big ? ea : eb;
                    sbig_q   <= a_big ? sa : sb;
                    ssmall_q <= a_big ? sb : sa;
                end
                ADD: begin
                    sum_q  <= sum_d;
                    sign_q <= sign_d;
                end
                NORM: begin
                    norm_q <= norm_d;
                    exp_q  <= exp_norm_d;
                end
                ROUND: begin
                    z_q     <= round_z_d;
                    flags_q <= round_flags_d;
                end
                OUT: begin
                    if (!out_valid_q)   out_valid_q <= 1'b1;
                    else if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Directed-vector bench: single and half precision instances, hand-computed results.
module tb_fp_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, in_valid32, in_ready32, op32, out_valid32, out_ready32;
    logic [31:0] a32, b32, z32;
    logic [3:0]  flags32;

    logic        rst16, in_valid16, in_ready16, op16, out_valid16, out_ready16;
    logic [15:0] a16, b16, z16;
    logic [3:0]  flags16;

    int n_vec = 0;
    int n_miscmp = 0;
    int lat;
    logic seen;

    fp_addsub u_dut32 (
        .clk       (clk),
        .rst       (rst32),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .op        (op32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .z         (z32),
        .flags     (flags32)
    );

    fp_addsub #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk       (clk),
        .rst       (rst16),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .op        (op16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .z         (z16),
        .flags     (flags16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic opv, input logic [31:0] ez, input logic [3:0] ef,
                         input int elat);
        int l;
        chk({tag, ".rdy_in"}, 64'(in_ready32), 64'd1);
        a32 = av; b32 = bv; op32 = opv; in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        l = 0;
        while (!out_valid32 && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        chk({tag, ".lat"}, 64'(l), 64'(elat));
        chk({tag, ".z"}, 64'(z32), 64'(ez));
        chk({tag, ".flags"}, 64'(flags32), 64'(ef));
        $display("vec %s: %h %s %h -> z=%h flags=%b lat=%0d", tag, av, opv ? "-" : "+", bv,
                 z32, flags32, l);
        @(posedge clk); #1;
        chk({tag, ".v_after"}, 64'(out_valid32), 64'd0);
        chk({tag, ".rdy_after"}, 64'(in_ready32), 64'd1);
    endtask

    initial begin
        rst32 = 1'b1; in_valid32 = 1'b0; op32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
        rst16 = 1'b1; in_valid16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst32 = 1'b0; rst16 = 1'b0;
        chk("rst.rdy", 64'(in_ready32), 64'd1);
        chk("rst.v", 64'(out_valid32), 64'd0);
        chk("rst.z", 64'(z32), 64'd0);
        chk("rst.flags", 64'(flags32), 64'd0);
        chk("rst16.rdy", 64'(in_ready16), 64'd1);

        run32("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6);
        run32("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 6);
        run32("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
        run32("max_plus_max",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6);
        run32("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6);
        run32("sub_plus_sub",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 6);
        run32("negz_negz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 6);
        run32("three_minus_1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 6);
        run32("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6);
        run32("round_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001, 6);
        run32("qnan_in",       32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2);
        run32("snan_in",       32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 2);
        run32("ninf_minus_1",  32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000, 2);
        run32("minnorm_sub",   32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000, 6);

        // Half precision: back-pressure hold, then abort and reset-vs-handshake priority.
        chk("h.rdy_in", 64'(in_ready16), 64'd1);
        a16 = 16'h3C00; b16 = 16'h3C00; op16 = 1'b0; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("h.lat", 64'(lat), 64'd6);
        chk("h.z", 64'(z16), 64'h4000);
        chk("h.flags", 64'(flags16), 64'd0);
        $display("vec half_one_plus_one: 3c00 + 3c00 -> z=%h flags=%b lat=%0d", z16, flags16, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("h.hold_v", 64'(out_valid16), 64'd1);
            chk("h.hold_z", 64'(z16), 64'h4000);
            chk("h.hold_rdy", 64'(in_ready16), 64'd0);
        end
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("h.xfer_v", 64'(out_valid16), 64'd0);
        chk("h.xfer_rdy", 64'(in_ready16), 64'd1);

        in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        chk("h.abort_rdy", 64'(in_ready16), 64'd1);
        chk("h.abort_v", 64'(out_valid16), 64'd0);
        chk("h.abort_z", 64'(z16), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid16) seen = 1'b1;
        end
        chk("h.abort_quiet", 64'(seen), 64'd0);
        $display("vec half_abort: reset mid-operation, out_valid seen=%0d", seen);

        in_valid16 = 1'b1; rst16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; rst16 = 1'b0;
        chk("h.rstpri_rdy", 64'(in_ready16), 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid16 || !in_ready16) seen = 1'b1;
        end
        chk("h.rstpri_quiet", 64'(seen), 64'd0);
        $display("vec half_rst_priority: handshake under reset, activity seen=%0d", seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
